lcd_bus_monitor: RTL and testbench

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

---
 rtl/lcd_bus_monitor.sv | 157 +++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 4-bit bus monitor: rebuilds bytes from E strobes and tracks
// the DDRAM address to report characters landing on a visible 16x2 cell.
module lcd_bus_monitor #(
  parameter int MIN_E_HIGH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] lcd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_row,
  output logic [3:0] char_col,
  output logic       clr,
  output logic       err
);

  localparam int CNT_W = $clog2(MIN_E_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MIN_E_HIGH);

  typedef enum logic {HI, LO} state_t;

  logic [5:0]       lcd_q;
  logic [CNT_W-1:0] e_cnt;
  logic [3:0]       nib_hold;
  logic             rs_hold;
  logic             strobe;
  logic             strobe_p1;
  logic [3:0]       nib_p1;
  logic             rs_p1;
  state_t           state;
  logic [3:0]       hi_nib;
  logic             hi_rs;
  logic [6:0]       addr;

  // Visible 16x2 window is 0x00..0x0F and 0x40..0x4F; the two 40-cell lines wrap into each other.
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  function automatic logic addr_visible(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  // Stage 0: bus sample, E-high qualification and last-high nibble capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_q    <= '0;
      e_cnt    <= '0;
      nib_hold <= '0;
      rs_hold  <= 1'b0;
    end else begin
      lcd_q <= lcd;
      if (lcd_q[4]) begin
        if (e_cnt != CNT_SAT) e_cnt <= e_cnt + 1'b1;
        nib_hold <= lcd_q[3:0];
        rs_hold  <= lcd_q[5];
      end else begin
        e_cnt <= '0;
      end
    end
  end

  assign strobe = !lcd_q[4] && (e_cnt == CNT_SAT);

  // Stage 1: registered strobe with its nibble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_p1 <= 1'b0;
      nib_p1    <= '0;
      rs_p1     <= 1'b0;
    end else begin
      strobe_p1 <= strobe;
      nib_p1    <= nib_hold;
      rs_p1     <= rs_hold;
    end
  end

  // Stage 2: nibble pairing FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HI;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_rs    <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;
      if (strobe_p1) begin
        case (state)
          HI: begin
            hi_nib <= nib_p1;
            hi_rs  <= rs_p1;
            state  <= LO;
          end
          LO: begin
            if (rs_p1 == hi_rs) begin
              byte_valid <= 1'b1;
              byte_data  <= {hi_nib, nib_p1};
              byte_rs    <= rs_p1;
              state      <= HI;
            end else begin
              // Mismatched RS: resynchronise by treating this nibble as a fresh high half.
              err    <= 1'b1;
              hi_nib <= nib_p1;
              hi_rs  <= rs_p1;
            end
          end
          default: state <= HI;
        endcase
      end
    end
  end

  // Stage 3: command decode and character placement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      clr        <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_row   <= 1'b0;
      char_col   <= '0;
    end else begin
      clr        <= 1'b0;
      char_valid <= 1'b0;
      if (byte_valid) begin
        if (!byte_rs) begin
          if (byte_data == 8'h01) begin
            addr <= '0;
            clr  <= 1'b1;
          end else if (byte_data[7:1] == 7'h01) begin
            addr <= '0;
          end else if (byte_data[7]) begin
            addr <= byte_data[6:0];
          end
        end else begin
          if (addr_visible(addr)) begin
            char_valid <= 1'b1;
            char_code  <= byte_data;
            char_row   <= addr[6];
            char_col   <= addr[3:0];
          end
          addr <= addr_inc(addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Bench for lcd_bus_monitor: drives nibble strobes on the bus and scores the
// reassembled bytes and visible characters against expected queues.
module tb_lcd_bus_monitor;

  logic       clk;
  logic       rst;
  logic [5:0] lcd;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_row;
  logic [3:0] char_col;
  logic       clr;
  logic       err;

  lcd_bus_monitor #(.MIN_E_HIGH(2)) dut (
    .clk(clk), .rst(rst), .lcd(lcd),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
    .char_valid(char_valid), .char_code(char_code), .char_row(char_row),
    .char_col(char_col), .clr(clr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       vis;
    logic       row;
    logic [3:0] col;
    logic       clr;
    logic [6:0] addr;
  } vec_t;

  typedef struct { logic rs; logic [7:0] data; } bexp_t;
  typedef struct { logic [7:0] code; logic row; logic [3:0] col; } cexp_t;

  bexp_t bq[$];
  cexp_t cq[$];
  vec_t  vecs[14];

  int compared   = 0;
  int mismatched = 0;
  int clr_cnt    = 0;
  int err_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (clr) clr_cnt++;
      if (err) err_cnt++;
      if (byte_valid) begin
        if (bq.size() == 0) begin
          chk("unexpected_byte_valid", {23'd0, byte_rs, byte_data}, 32'hFFFF_FFFF);
        end else begin
          bexp_t b;
          b = bq.pop_front();
          chk("byte_data", byte_data, b.data);
          chk("byte_rs", byte_rs, b.rs);
        end
      end
      if (char_valid) begin
        if (cq.size() == 0) begin
          chk("unexpected_char_valid", {19'd0, char_row, char_col, char_code}, 32'hFFFF_FFFF);
        end else begin
          cexp_t c;
          c = cq.pop_front();
          chk("char_code", char_code, c.code);
          chk("char_row", char_row, c.row);
          chk("char_col", char_col, c.col);
        end
      end
    end
  end

  task automatic nibble(input logic rs, input logic [3:0] n, input int hi_cycles);
    lcd = {rs, 1'b1, n};
    repeat (hi_cycles) @(posedge clk);
    #1 lcd = {rs, 1'b0, n};
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d);
    nibble(rs, d[7:4], 2);
    nibble(rs, d[3:0], 2);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic rs, input logic [7:0] d);
    bexp_t b;
    b.rs = rs;
    b.data = d;
    bq.push_back(b);
  endtask

  task automatic expect_char(input logic [7:0] code, input logic row, input logic [3:0] col);
    cexp_t c;
    c.code = code;
    c.row = row;
    c.col = col;
    cq.push_back(c);
  endtask

  initial begin
    int lat;
    int clr_before;
    int err_before;
    logic found;

    vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 4'd0, 1'b0, 7'h01};
    vecs[1]  = '{1'b0, 8'hC5, 1'b0, 1'b0, 4'd0, 1'b0, 7'h45};
    vecs[2]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 4'd5, 1'b0, 7'h46};
    vecs[3]  = '{1'b0, 8'hA7, 1'b0, 1'b0, 4'd0, 1'b0, 7'h27};
    vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0, 7'h40};
    vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b1, 4'd0, 1'b0, 7'h41};
    vecs[6]  = '{1'b0, 8'h01, 1'b0, 1'b0, 4'd0, 1'b1, 7'h00};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 7'h01};
    vecs[8]  = '{1'b0, 8'h38, 1'b0, 1'b0, 4'd0, 1'b0, 7'h01};
    vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b0, 4'd1, 1'b0, 7'h02};
    vecs[10] = '{1'b0, 8'h03, 1'b0, 1'b0, 4'd0, 1'b0, 7'h00};
    vecs[11] = '{1'b0, 8'hE7, 1'b0, 1'b0, 4'd0, 1'b0, 7'h67};
    vecs[12] = '{1'b1, 8'h66, 1'b0, 1'b0, 4'd0, 1'b0, 7'h00};
    vecs[13] = '{1'b1, 8'h77, 1'b1, 1'b0, 4'd0, 1'b0, 7'h01};

    // Reset state with a busy bus
    rst = 1'b0;
    lcd = 6'h3F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_char_valid", char_valid, 1'b0);
    chk("rst_char_code", char_code, 8'h00);
    chk("rst_clr", clr, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", dut.addr, 7'h00);
    @(posedge clk);
    #1 lcd = 6'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Latency: byte_valid three edges after E is driven low (two after it is registered)
    expect_byte(1'b0, 8'h80);
    nibble(1'b0, 4'h8, 2);
    lcd = {1'b0, 1'b1, 4'h0};
    repeat (2) @(posedge clk);
    #1 lcd = {1'b0, 1'b0, 4'h0};
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (byte_valid) found = 1'b1;
    end
    chk("byte_latency", lat, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("addr_after_0x80", dut.addr, 7'h00);

    // Table of whole bytes
    for (int i = 0; i < 14; i++) begin
      clr_before = clr_cnt;
      expect_byte(vecs[i].rs, vecs[i].data);
      if (vecs[i].vis) expect_char(vecs[i].data, vecs[i].row, vecs[i].col);
      send_byte(vecs[i].rs, vecs[i].data);
      chk($sformatf("addr_vec%0d", i), dut.addr, vecs[i].addr);
      chk($sformatf("clr_vec%0d", i), clr_cnt - clr_before, vecs[i].clr);
    end

    // Short E pulses in HI and in LO are ignored
    nibble(1'b1, 4'hF, 1);
    expect_byte(1'b0, 8'h42);
    nibble(1'b0, 4'h4, 2);
    nibble(1'b0, 4'h9, 1);
    nibble(1'b0, 4'h2, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("addr_after_short_e", dut.addr, 7'h01);

    // RS mismatch: err, no byte, mismatched nibble becomes the high half
    err_before = err_cnt;
    nibble(1'b0, 4'h1, 2);
    nibble(1'b1, 4'h2, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("err_pulse", err_cnt - err_before, 1);
    expect_byte(1'b1, 8'h23);
    expect_char(8'h23, 1'b0, 4'd1);
    nibble(1'b1, 4'h3, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("addr_after_resync", dut.addr, 7'h02);
    chk("err_no_extra", err_cnt - err_before, 1);

    // Reset in the middle of a byte drops the pending high nibble
    nibble(1'b1, 4'h7, 2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_addr", dut.addr, 7'h00);
    chk("midrst_char_code", char_code, 8'h00);
    chk("midrst_byte_data", byte_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    expect_byte(1'b1, 8'h30);
    expect_char(8'h30, 1'b0, 4'd0);
    send_byte(1'b1, 8'h30);
    chk("addr_after_reset_byte", dut.addr, 7'h01);

    repeat (5) @(posedge clk);
    #1;
    chk("byte_queue_drained", bq.size(), 0);
    chk("char_queue_drained", cq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
